btn_bcd_bank: RTL



---
 rtl/btn_bcd_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/btn_bcd_bank.sv
// btn_bcd_bank: a bank of N_CH button-driven decimal digit counters.
//
// Each button is synchronised on the sampling tick (ce & EN) and edge-detected.
// A press steps its digit up or down, modulo DIG_MAX+1. With CASCADE=1 the
// digits form one multi-digit counter: a wrap on digit i steps digit i+1 in
// the same cycle.
//
// Optional feature macro: BTN_REPEAT_EN adds hold-to-auto-repeat per channel
// (first repeat after REP_DLY held ticks, then every REP_PER ticks).
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   ce   in   sampling tick, one-cycle pulse
//   EN   in   tick gate (effective tick = ce & EN)
//   UP   in   1 = increment, 0 = decrement (all channels)
//   BTN  in   [N_CH]   raw button levels
//   DEC  out  [4*N_CH] digits, channel i at DEC[4*i+3:4*i]
//   CO   out  registered carry/borrow pulse out of the top channel

// One channel: sync/edge detect, optional hold repeat, and the digit register.
// o_cout is combinational (step & wrap) so the bank can ripple it.
module btn_bcd_lane #(
  parameter int DIG_MAX = 9
`ifdef BTN_REPEAT_EN
  ,
  parameter int REP_DLY = 50,
  parameter int REP_PER = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tk,
  input  logic       i_btn,
  input  logic       i_up,
  input  logic       i_cin,
  output logic [3:0] o_dig,
  output logic       o_cout
);
  localparam logic [3:0] DMAX = 4'(DIG_MAX);

  logic       r_q1, r_q2;
  logic [3:0] r_dig;
  logic       w_st, w_rep, w_rq, w_wrap;

  assign w_st   = i_tk & r_q1 & ~r_q2;
  assign w_wrap = i_up ? (r_dig == DMAX) : (r_dig == 4'd0);
  // Any mix of press / repeat / carry-in is a single step.
  assign w_rq   = w_st | w_rep | i_cin;
  assign o_cout = w_rq & w_wrap;
  assign o_dig  = r_dig;

`ifdef BTN_REPEAT_EN
  localparam int CW = $clog2(REP_DLY + 1);
  // r_hold holds (held ticks - 1) up to the first repeat; the repeat tick is
  // the one that would bring the held count to REP_DLY. After a repeat the
  // counter is rewound so the next repeat lands REP_PER ticks later. A period
  // longer than the initial delay is clamped to the delay.
  localparam logic [CW-1:0] FIRE = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] RLD  = CW'((REP_PER <= REP_DLY) ? (REP_DLY - REP_PER) : 0);

  logic [CW-1:0] r_hold;
  logic          w_held;

  assign w_held = i_tk & r_q1 & r_q2;
  assign w_rep  = w_held & (r_hold == FIRE);

  always_ff @(posedge clk) begin
    if (rst || !r_q1)  r_hold <= '0;
    else if (w_rep)    r_hold <= RLD;
    else if (w_held)   r_hold <= r_hold + 1'b1;
  end
`else
  assign w_rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1  <= 1'b0;
      r_q2  <= 1'b0;
      r_dig <= 4'd0;
    end else begin
      if (i_tk) begin
        r_q1 <= i_btn;
        r_q2 <= r_q1;
      end
      if (w_rq) begin
        if (i_up) r_dig <= w_wrap ? 4'd0 : r_dig + 4'd1;
        else      r_dig <= w_wrap ? DMAX : r_dig - 4'd1;
      end
    end
  end
endmodule

module btn_bcd_bank #(
  parameter int N_CH    = 4,
  parameter int DIG_MAX = 9,
  parameter int CASCADE = 0,
  parameter int REP_DLY = 50,
  parameter int REP_PER = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              EN,
  input  logic              UP,
  input  logic [N_CH-1:0]   BTN,
  output logic [4*N_CH-1:0] DEC,
  output logic              CO
);
  localparam logic CASC = (CASCADE != 0);

  logic w_tk;
  logic r_co;

  assign w_tk = ce & EN;

  if (N_CH < 1 || N_CH > 8 || DIG_MAX < 1 || DIG_MAX > 15 ||
      REP_DLY < 1 || REP_PER < 1) begin : g_bad_cfg
    $error("btn_bcd_bank: parameter out of range");
  end

  // Carry links live inside each generate block so the ripple chain is a set
  // of distinct nets rather than one self-referencing vector.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    logic w_cin, w_cout;

    if (i == 0) begin : g_head
      assign w_cin = 1'b0;
    end else begin : g_link
      assign w_cin = CASC & g_lane[i-1].w_cout;
    end

    btn_bcd_lane #(
      .DIG_MAX(DIG_MAX)
`ifdef BTN_REPEAT_EN
      ,
      .REP_DLY(REP_DLY),
      .REP_PER(REP_PER)
`endif
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_tk  (w_tk),
      .i_btn (BTN[i]),
      .i_up  (UP),
      .i_cin (w_cin),
      .o_dig (DEC[4*i +: 4]),
      .o_cout(w_cout)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_co <= 1'b0;
    else     r_co <= g_lane[N_CH-1].w_cout;
  end

  assign CO = r_co;
endmodule
